// File: rtl/eth_rx_mac.sv
// eth_rx_mac: receive MAC framer for the RGMII byte stream.
// Strips preamble/SFD, checks CRC-32 and frame length, delays the stream by
// four bytes so the FCS is never emitted, and keeps good/bad frame counters.
module eth_rx_mac #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_dv,
    input  logic             rx_er,
    input  logic [7:0]       rxd,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic             m_err,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    // Byte counter must hold MAX_LEN plus the overflow probe value.
    localparam int LW = $clog2(MAX_LEN + 2);
    localparam logic [LW-1:0] LEN_MIN  = LW'(MIN_LEN);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_FOUR = LW'(4);
    localparam logic [LW-1:0] LEN_FIVE = LW'(5);

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [3:0][7:0]  dl_q, dl_d;
    logic [7:0]       pend_q, pend_d;
    logic             err_q, err_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             m_err_q, m_err_d;
    logic [CNT_W-1:0] ok_q, ok_d;
    logic [CNT_W-1:0] bad_q, bad_d;

    logic err_line;
    logic frame_bad;

    // Reflected CRC-32 (poly 0x04C11DB7), one byte LSB-first, no final xor.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign err_line = rx_dv & (rx_dv ^ rx_er);

    // Framing FSM, FCS delay line, output staging and frame counters.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        dl_d      = dl_q;
        pend_d    = pend_q;
        err_d     = err_q;
        m_data_d  = m_data_q;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        m_err_d   = 1'b0;
        ok_d      = ok_q;
        bad_d     = bad_q;
        // Residue over data+FCS is constant when the FCS matches.
        frame_bad = (crc_q != CRC_RESIDUE) || (cnt_q < LEN_MIN) || err_q || (cnt_q < LEN_FIVE);

        case (state_q)
            S_IDLE: begin
                if (rx_dv) state_d = (rxd == 8'h55) ? S_PRE : S_DROP;
            end
            S_PRE: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end else if (err_line) begin
                    state_d = S_DROP;
                end else if (rxd == 8'hD5) begin
                    state_d = S_PAY;
                    crc_d   = 32'hFFFFFFFF;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (rxd != 8'h55) begin
                    state_d = S_DROP;
                end
            end
            S_PAY: begin
                if (rx_dv) begin
                    if (cnt_q == LEN_MAX) begin
                        // One byte past the limit: close the frame as oversize.
                        if (cnt_q >= LEN_FIVE) begin
                            m_valid_d = 1'b1;
                            m_last_d  = 1'b1;
                            m_err_d   = 1'b1;
                            m_data_d  = pend_q;
                        end
                        if (bad_q != CNT_SAT) bad_d = bad_q + 1'b1;
                        state_d = S_DROP;
                    end else begin
                        crc_d = crc_byte(crc_q, rxd);
                        cnt_d = cnt_q + 1'b1;
                        dl_d  = {dl_q[2:0], rxd};
                        if (err_line) err_d = 1'b1;
                        // pend trails the line by five bytes; it is first
                        // loaded with the destination MAC's first byte.
                        if (cnt_q >= LEN_FOUR) pend_d = dl_q[3];
                        if (cnt_q >= LEN_FIVE) begin
                            m_valid_d = 1'b1;
                            m_data_d  = pend_q;
                        end
                    end
                end else begin
                    // End of frame: the four bytes left in the delay line are the FCS.
                    if (cnt_q >= LEN_FIVE) begin
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b1;
                        m_err_d   = frame_bad;
                        m_data_d  = pend_q;
                    end
                    if (frame_bad) begin
                        if (bad_q != CNT_SAT) bad_d = bad_q + 1'b1;
                    end else begin
                        if (ok_q != CNT_SAT) ok_d = ok_q + 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (!rx_dv) state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            crc_q     <= '0;
            dl_q      <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_err_q   <= 1'b0;
            ok_q      <= '0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            dl_q      <= dl_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_err_q   <= m_err_d;
            ok_q      <= ok_d;
            bad_q     <= bad_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_err   = m_err_q;
    assign ok_cnt  = ok_q;
    assign bad_cnt = bad_q;

endmodule

// File: tb/tb_eth_rx_mac.sv
// tb_eth_rx_mac: frame-level reference model driven with random payloads.
module tb_eth_rx_mac;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst = 1'b0, rx_dv = 1'b0, rx_er = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic [7:0] m_data;
    logic m_valid, m_last, m_err;
    logic [CNT_W-1:0] ok_cnt, bad_cnt;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    eth_rx_mac #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_err(m_err),
        .ok_cnt(ok_cnt), .bad_cnt(bad_cnt)
    );

    logic [7:0] frm[$];
    logic [7:0] got_d[$];
    logic       got_l[$];
    logic       got_e[$];
    logic [7:0] exp_d[$];
    logic       exp_last, exp_err;
    int         exp_ok = 0, exp_bad = 0;
    int         stray = 0;
    logic [7:0] snap_d;
    logic       snap_v, snap_l, snap_e;
    logic [CNT_W-1:0] snap_ok, snap_bad, snap_pre_ok;

    // Beat collector; flags and err outside their qualifiers are counted as stray.
    always @(negedge clk) begin
        if (m_valid) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            got_e.push_back(m_err);
        end else if (m_last || m_err) begin
            stray++;
        end
        if (m_valid && m_err && !m_last) stray++;
    end

    // Standard Ethernet FCS value of frm[0..n-1].
    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic add_fcs();
        logic [31:0] c = crc32(frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic clear_got();
        got_d.delete(); got_l.delete(); got_e.delete();
    endtask

    // Expected payload/last/err/counters for frm (bytes after SFD).
    task automatic model(input int lerr);
        int n = frm.size();
        logic [31:0] c;
        logic fcs_ok;
        exp_d.delete(); exp_last = 1'b0; exp_err = 1'b0;
        if (n > MAX_LEN) begin
            for (int i = 0; i < MAX_LEN - 4; i++) exp_d.push_back(frm[i]);
            exp_last = 1'b1; exp_err = 1'b1;
            if (exp_bad < CNT_MAX) exp_bad++;
        end else if (n < 5) begin
            if (exp_bad < CNT_MAX) exp_bad++;
        end else begin
            c = crc32(n - 4);
            fcs_ok = (c == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
            for (int i = 0; i < n - 4; i++) exp_d.push_back(frm[i]);
            exp_last = 1'b1;
            exp_err = !fcs_ok || (n < MIN_LEN) || (lerr >= 0);
            if (exp_err) begin if (exp_bad < CNT_MAX) exp_bad++; end
            else begin if (exp_ok < CNT_MAX) exp_ok++; end
        end
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk);
        rx_dv = dv; rx_er = er; rxd = d;
    endtask

    task automatic send_frame(input int lerr, input int rst_at, input int idle);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < frm.size(); i++) begin
            drive(1'b1, (i != lerr), frm[i]);
            if (rst) rst = 1'b0;
            if (i == rst_at) begin
                snap_pre_ok = ok_cnt;
                rst = 1'b1;
                #1;
                snap_d = m_data; snap_v = m_valid; snap_l = m_last; snap_e = m_err;
                snap_ok = ok_cnt; snap_bad = bad_cnt;
            end
        end
        rst = 1'b0;
        for (int i = 0; i < idle; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b want=0", m_last); end
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", m_err); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", m_data); end
        checks++; if (ok_cnt !== '0) begin errors++; $display("FAIL reset_ok got=%0d want=0", ok_cnt); end
        checks++; if (bad_cnt !== '0) begin errors++; $display("FAIL reset_bad got=%0d want=0", bad_cnt); end
        rst = 1'b0;
        exp_ok = 0; exp_bad = 0;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        int mism = 0;
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i));
        add_fcs(); model(-1); clear_got();
        send_frame(-1, -1, 3);
        checks++; if (got_d.size() != 60) begin errors++; $display("FAIL good_beats got=%0d want=60", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 60; i++) if (got_d[i] !== 8'(i)) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL good_data mismatching=%0d want=0", mism); end
        checks++; if (got_l.size() == 0 || got_l[$] !== 1'b1 || got_d[$] !== 8'h3B || got_e[$] !== 1'b0)
            begin errors++; $display("FAIL good_last beats=%0d want last on 3B with err=0", got_d.size()); end
        checks++; if (ok_cnt !== CNT_W'(1) || bad_cnt !== CNT_W'(0))
            begin errors++; $display("FAIL good_cnt ok=%0d bad=%0d want 1/0", ok_cnt, bad_cnt); end
    endtask

    task automatic test_crc_error();
        int mism = 0;
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i));
        add_fcs();
        frm[10] = 8'hF5;
        model(-1); clear_got();
        send_frame(-1, -1, 3);
        checks++; if (got_d.size() != 60) begin errors++; $display("FAIL crc_beats got=%0d want=60", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL crc_data mismatching=%0d want=0", mism); end
        checks++; if (got_l.size() == 0 || got_l[$] !== 1'b1 || got_e[$] !== 1'b1)
            begin errors++; $display("FAIL crc_last want last with err=1"); end
        checks++; if (ok_cnt !== CNT_W'(1) || bad_cnt !== CNT_W'(1))
            begin errors++; $display("FAIL crc_cnt ok=%0d bad=%0d want 1/1", ok_cnt, bad_cnt); end
    endtask

    task automatic test_runt();
        int lens[2] = '{40, 59};
        foreach (lens[k]) begin
            int mism = 0;
            frm.delete();
            for (int i = 0; i < lens[k]; i++) frm.push_back(8'($urandom));
            add_fcs(); model(-1); clear_got();
            send_frame(-1, -1, 3);
            checks++; if (got_d.size() != lens[k]) begin errors++; $display("FAIL runt_beats got=%0d want=%0d", got_d.size(), lens[k]); end
            for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) mism++;
            checks++; if (mism != 0 || got_l.size() == 0 || got_l[$] !== 1'b1 || got_e[$] !== 1'b1)
                begin errors++; $display("FAIL runt_last mismatching=%0d want last with err=1", mism); end
            checks++; if (bad_cnt !== CNT_W'(exp_bad)) begin errors++; $display("FAIL runt_bad got=%0d want=%0d", bad_cnt, exp_bad); end
        end
    endtask

    task automatic test_line_error();
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
        add_fcs(); model(20); clear_got();
        send_frame(20, -1, 3);
        checks++; if (got_d.size() != 60 || got_l[$] !== 1'b1 || got_e[$] !== 1'b1)
            begin errors++; $display("FAIL line_last beats=%0d want 60 with final err=1", got_d.size()); end
        checks++; if (bad_cnt !== CNT_W'(exp_bad) || ok_cnt !== CNT_W'(exp_ok))
            begin errors++; $display("FAIL line_cnt ok=%0d bad=%0d want %0d/%0d", ok_cnt, bad_cnt, exp_ok, exp_bad); end
    endtask

    task automatic test_oversize();
        int lens[2] = '{1600, 1514};
        foreach (lens[k]) begin
            int mism = 0;
            frm.delete();
            for (int i = 0; i < lens[k]; i++) frm.push_back(8'($urandom));
            if (lens[k] == 1514) add_fcs();
            model(-1); clear_got();
            send_frame(-1, -1, 3);
            checks++; if (got_d.size() != MAX_LEN - 4) begin errors++; $display("FAIL over_beats len=%0d got=%0d want=%0d", frm.size(), got_d.size(), MAX_LEN - 4); end
            for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) mism++;
            checks++; if (mism != 0) begin errors++; $display("FAIL over_data len=%0d mismatching=%0d", frm.size(), mism); end
            checks++; if (got_l.size() == 0 || got_l[$] !== 1'b1 || got_e[$] !== exp_err)
                begin errors++; $display("FAIL over_last len=%0d want last err=%b", frm.size(), exp_err); end
            checks++; if (ok_cnt !== CNT_W'(exp_ok) || bad_cnt !== CNT_W'(exp_bad))
                begin errors++; $display("FAIL over_cnt ok=%0d bad=%0d want %0d/%0d", ok_cnt, bad_cnt, exp_ok, exp_bad); end
        end
    endtask

    task automatic test_drop();
        clear_got();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 8'hAA);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, (i == 0) ? 8'h33 : 8'hD5);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'h55);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        checks++; if (got_d.size() != 0) begin errors++; $display("FAIL drop_beats got=%0d want=0", got_d.size()); end
        checks++; if (ok_cnt !== CNT_W'(exp_ok) || bad_cnt !== CNT_W'(exp_bad))
            begin errors++; $display("FAIL drop_cnt ok=%0d bad=%0d want %0d/%0d", ok_cnt, bad_cnt, exp_ok, exp_bad); end
        frm.delete();
        for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
        model(-1); clear_got();
        send_frame(-1, -1, 3);
        checks++; if (got_d.size() != 0 || bad_cnt !== CNT_W'(exp_bad))
            begin errors++; $display("FAIL short_frame beats=%0d bad=%0d want 0/%0d", got_d.size(), bad_cnt, exp_bad); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            int mism = 0;
            int lerr = -1;
            frm.delete();
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 4)) frm.push_back(8'($urandom));
            end else begin
                repeat ($urandom_range(1, 100)) frm.push_back(8'($urandom));
                add_fcs();
                if ($urandom_range(0, 3) == 0) frm[$urandom_range(0, frm.size() - 1)] ^= 8'($urandom_range(1, 255));
            end
            if ($urandom_range(0, 4) == 0) lerr = $urandom_range(0, frm.size() - 1);
            model(lerr); clear_got();
            send_frame(lerr, -1, $urandom_range(3, 5));
            for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) if (got_d[i] !== exp_d[i]) mism++;
            checks++;
            if (got_d.size() != exp_d.size() || mism != 0) begin
                errors++; $display("FAIL rand_data frame=%0d len=%0d beats=%0d want=%0d mismatching=%0d", f, frm.size(), got_d.size(), exp_d.size(), mism);
            end else if (exp_last && (got_l[$] !== 1'b1 || got_e[$] !== exp_err)) begin
                errors++; $display("FAIL rand_last frame=%0d last=%b err=%b want 1/%b", f, got_l[$], got_e[$], exp_err);
            end
            checks++; if (ok_cnt !== CNT_W'(exp_ok) || bad_cnt !== CNT_W'(exp_bad))
                begin errors++; $display("FAIL rand_cnt frame=%0d ok=%0d bad=%0d want %0d/%0d", f, ok_cnt, bad_cnt, exp_ok, exp_bad); end
        end
    endtask

    task automatic test_saturation();
        for (int f = 0; f < CNT_MAX + 2; f++) begin
            frm.delete();
            for (int i = 0; i < MIN_LEN - 4; i++) frm.push_back(8'($urandom));
            add_fcs(); model(-1); clear_got();
            send_frame(-1, -1, 3);
        end
        checks++; if (ok_cnt !== CNT_W'(CNT_MAX) || exp_ok != CNT_MAX)
            begin errors++; $display("FAIL sat_ok got=%0d want=%0d", ok_cnt, CNT_MAX); end
        checks++; if (got_e.size() == 0 || got_e[$] !== 1'b0) begin errors++; $display("FAIL sat_min_len want err=0 at exactly MIN_LEN"); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] frame_a[$];
        int mism = 0, lasts = 0;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        exp_ok = 0; exp_bad = 0;
        clear_got();
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
        add_fcs(); model(-1);
        frame_a = exp_d;
        send_frame(-1, -1, 1);
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
        add_fcs();
        send_frame(-1, 29, 3);
        checks++; if (snap_pre_ok !== CNT_W'(1)) begin errors++; $display("FAIL b2b_first_ok got=%0d want=1", snap_pre_ok); end
        checks++; if (snap_v !== 1'b0 || snap_l !== 1'b0 || snap_e !== 1'b0 || snap_d !== 8'h00 || snap_ok !== '0 || snap_bad !== '0)
            begin errors++; $display("FAIL b2b_reset v=%b l=%b e=%b d=%h ok=%0d bad=%0d want all 0", snap_v, snap_l, snap_e, snap_d, snap_ok, snap_bad); end
        for (int i = 0; i < got_d.size(); i++) begin
            if (i < 60) begin if (got_d[i] !== frame_a[i]) mism++; end
            else if (got_d[i] !== frm[i - 60]) mism++;
            if (got_l[i]) lasts++;
        end
        checks++; if (got_d.size() < 60 || mism != 0 || got_l[59] !== 1'b1 || got_e[59] !== 1'b0 || lasts != 1)
            begin errors++; $display("FAIL b2b_stream beats=%0d mismatching=%0d lasts=%0d want one last at beat 60", got_d.size(), mism, lasts); end
        exp_ok = 0; exp_bad = 0;
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
        add_fcs(); model(-1); clear_got();
        send_frame(-1, -1, 3);
        checks++; if (got_d.size() != 60 || ok_cnt !== CNT_W'(1) || bad_cnt !== CNT_W'(0))
            begin errors++; $display("FAIL b2b_after beats=%0d ok=%0d bad=%0d want 60/1/0", got_d.size(), ok_cnt, bad_cnt); end
        checks++; if (stray != 0) begin errors++; $display("FAIL stray_flags got=%0d want=0", stray); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_runt();
        test_line_error();
        test_oversize();
        test_drop();
        test_random();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
